multi_phase_traffic_ctrl: RTL

//  Round-robin signal controller for NUM_PHASES conflicting approaches. Generalises the two-road controller.

---
 rtl/multi_phase_traffic_ctrl_pkg.sv | 25 ++
 rtl/multi_phase_traffic_ctrl_if.sv | 24 ++
 rtl/multi_phase_traffic_ctrl_dwell_timer.sv | 26 ++
 rtl/multi_phase_traffic_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/multi_phase_traffic_ctrl_pkg.sv
// Shared types for the multi-phase traffic controller: FSM states, lamp codes
// and the round-robin phase step.
package multi_phase_traffic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_WALK   = 3'd3,
    ST_FLASH  = 3'd4
  } state_e;

  // One-hot lamp drive per approach; all-zero means the lamp is dark.
  typedef enum logic [2:0] {
    LAMP_OFF = 3'b000,
    LAMP_GRN = 3'b001,
    LAMP_YEL = 3'b010,
    LAMP_RED = 3'b100
  } lamp_e;

  function automatic int unsigned next_phase(int unsigned ph, int unsigned num_phases);
    return (ph + 1 >= num_phases) ? '0 : ph + 1;
  endfunction

endpackage

// File: rtl/multi_phase_traffic_ctrl_if.sv
// Sensor/button inputs and lamp-driver outputs of the traffic controller.
// The controller sits on the slave side; the sync stage / bench is the master.
interface multi_phase_traffic_ctrl_if #(
  parameter int NUM_PHASES = 4
) ();
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic                    err;
  logic [NUM_PHASES-1:0]   ped_req;
  logic [3*NUM_PHASES-1:0] light;
  logic                    walk;
  logic [PH_W-1:0]         active_ph;
  logic                    fault;

  modport master (
    output err, ped_req,
    input  light, walk, active_ph, fault
  );

  modport slave (
    input  err, ped_req,
    output light, walk, active_ph, fault
  );
endinterface

// File: rtl/multi_phase_traffic_ctrl_dwell_timer.sv
// Dwell down-counter: load a value, count down to zero and hold there.
// done is high while the count is zero, i.e. in the last cycle of a dwell.
module multi_phase_traffic_ctrl_dwell_timer #(
  parameter int                 TIMER_W   = 4,
  parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the processes run in.
  always_ff @(posedge clk) begin
    if (reset)               count <= RESET_VAL;
    else if (load)           count <= value;
    else if (count != '0)    count <= count - TIMER_W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Round-robin controller for NUM_PHASES conflicting approaches with all-red
// clearance, a latched pedestrian walk interval and a flashing-red fault mode.
module multi_phase_traffic_ctrl
  import multi_phase_traffic_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TIMER_W    = 4,
  parameter int GREEN_T    = 8,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int WALK_T     = 6,
  parameter int FLASH_T    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  multi_phase_traffic_ctrl_if.slave  bus
);

  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_T  - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LD = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] WALK_LD   = TIMER_W'(WALK_T   - 1);
  localparam logic [TIMER_W-1:0] FLASH_LD  = TIMER_W'(FLASH_T  - 1);
  localparam logic [PH_W-1:0]    LAST_PH   = PH_W'(NUM_PHASES - 1);

  state_e              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                walk_pend_q, walk_pend_d;
  logic                flash_red_q, flash_red_d;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_val;
  logic                timer_done;
  logic [3*NUM_PHASES-1:0] light_d;

  multi_phase_traffic_ctrl_dwell_timer #(
    .TIMER_W   (TIMER_W),
    .RESET_VAL (ALLRED_LD)
  ) u_dwell_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_val),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ALLRED;
      ph_q        <= LAST_PH;
      walk_pend_q <= 1'b0;
      flash_red_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      walk_pend_q <= walk_pend_d;
      flash_red_q <= flash_red_d;
    end
  end

  // NOTE: every variable written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    flash_red_d = flash_red_q;
    timer_load  = 1'b0;
    timer_val   = ALLRED_LD;

    if (bus.err) begin
      // Fault preempts the dwell; flash starts on red and toggles each FLASH_T.
      state_d = ST_FLASH;
      if (state_q != ST_FLASH) begin
        flash_red_d = 1'b1;
        timer_load  = 1'b1;
        timer_val   = FLASH_LD;
      end else if (timer_done) begin
        flash_red_d = ~flash_red_q;
        timer_load  = 1'b1;
        timer_val   = FLASH_LD;
      end
    end else begin
      case (state_q)
        ST_FLASH: begin
          state_d    = ST_ALLRED;
          ph_d       = LAST_PH;
          timer_load = 1'b1;
          timer_val  = ALLRED_LD;
        end
        ST_GREEN: if (timer_done) begin
          state_d    = ST_YELLOW;
          timer_load = 1'b1;
          timer_val  = YELLOW_LD;
        end
        ST_YELLOW: if (timer_done) begin
          state_d    = ST_ALLRED;
          timer_load = 1'b1;
          timer_val  = ALLRED_LD;
        end
        ST_ALLRED: if (timer_done) begin
          timer_load = 1'b1;
          if (walk_pend_q) begin
            state_d   = ST_WALK;
            timer_val = WALK_LD;
          end else begin
            state_d   = ST_GREEN;
            ph_d      = PH_W'(next_phase(32'(ph_q), NUM_PHASES));
            timer_val = GREEN_LD;
          end
        end
        ST_WALK: if (timer_done) begin
          state_d    = ST_GREEN;
          ph_d       = PH_W'(next_phase(32'(ph_q), NUM_PHASES));
          timer_load = 1'b1;
          timer_val  = GREEN_LD;
        end
        default: begin
          state_d    = ST_ALLRED;
          timer_load = 1'b1;
          timer_val  = ALLRED_LD;
        end
      endcase
    end

    // Requests seen during WALK are already being served; the clear on WALK
    // entry outranks a request arriving in the same cycle.
    walk_pend_d = walk_pend_q;
    if (bus.err || state_q == ST_FLASH)
      walk_pend_d = 1'b0;
    else if (state_d == ST_WALK && state_q != ST_WALK)
      walk_pend_d = 1'b0;
    else if (state_q != ST_WALK && |bus.ped_req)
      walk_pend_d = 1'b1;
  end

  // Lamp decode looks only at registered state, so inputs never reach the lamps
  // combinationally and at most the active phase is non-red outside FLASH.
  always_comb begin
    light_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      lamp_e lamp;
      lamp = LAMP_RED;
      case (state_q)
        ST_FLASH:  lamp = flash_red_q ? LAMP_RED : LAMP_OFF;
        ST_GREEN:  if (32'(ph_q) == i) lamp = LAMP_GRN;
        ST_YELLOW: if (32'(ph_q) == i) lamp = LAMP_YEL;
        default:   lamp = LAMP_RED;
      endcase
      light_d[3*i +: 3] = lamp;
    end
  end

  assign bus.light     = light_d;
  assign bus.walk      = (state_q == ST_WALK);
  assign bus.fault     = (state_q == ST_FLASH);
  assign bus.active_ph = ph_q;

endmodule
